// File: rtl/display_scroll_mux.sv
// display_scroll_mux
//   Takes 5-bit characters with a parity bit over a valid/ready handshake and
//   buffers them in a FIFO. It scrolls them into an N-digit window and
//   time-multiplexes that window onto one shared 7-segment bus.
//   Handshake: a character is taken on any rising clk edge where
//   in_valid & in_ready are both high. E and P must stay stable until then.
//   in_ready is low while rst is high, and otherwise follows !full.
//   Optional feature: define DISPLAY_SCROLL_ERR_DROP_EN to drop characters
//   that fail the parity check instead of buffering them. They still update
//   valid and err_count.
module display_scroll_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int DEPTH       = 8,
   parameter int REFRESH_DIV = 1000,
   parameter int SCROLL_DIV  = 50000000,
   parameter int ODD_PARITY  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4:0]                E,
   input  logic                      P,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      valid,
   output logic [7:0]                err_count,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(SCROLL_DIV);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int DW = $clog2(NUM_DIGITS);
   localparam logic [SW-1:0] SCROLL_MAX  = SW'(SCROLL_DIV - 1);
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] SEL_MAX     = DW'(NUM_DIGITS - 1);
   localparam logic          PAR_TARGET  = (ODD_PARITY != 0);
   localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

   // FIFO storage: each entry is {parity_ok, code}
   logic [5:0]      r_mem [DEPTH];
   logic [AW:0]     r_wr_ptr;
   logic [AW:0]     r_rd_ptr;

   // Scroll window: digit 0 is the newest character
   logic [4:0]            r_dig_code [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_dig_ok;
   logic [NUM_DIGITS-1:0] r_dig_occ;

   logic [SW-1:0]   r_scnt;
   logic [RW-1:0]   r_rcnt;
   logic [DW-1:0]   r_sel;
   logic            r_valid;
   logic [7:0]      r_err;

   logic            w_full;
   logic            w_empty;
   logic            w_ok;
   logic            w_accept;
   logic            w_wr_en;
   logic            w_tick;
   logic            w_pop;
   logic [5:0]      w_head;
   logic [6:0]      w_seg;

   // Standard 5-bit character map: 0-F hex, then letters and marks
   function automatic logic [6:0] char_map(input logic [4:0] c);
      logic [6:0] s;
      case (c)
         5'd0:  s = 7'h7E;
         5'd1:  s = 7'h30;
         5'd2:  s = 7'h6D;
         5'd3:  s = 7'h79;
         5'd4:  s = 7'h33;
         5'd5:  s = 7'h5B;
         5'd6:  s = 7'h5F;
         5'd7:  s = 7'h70;
         5'd8:  s = 7'h7F;
         5'd9:  s = 7'h7B;
         5'd10: s = 7'h77;   // A
         5'd11: s = 7'h1F;   // b
         5'd12: s = 7'h4E;   // C
         5'd13: s = 7'h3D;   // d
         5'd14: s = 7'h4F;   // E
         5'd15: s = 7'h47;   // F
         5'd16: s = 7'h37;   // H
         5'd17: s = 7'h3C;   // J
         5'd18: s = 7'h0E;   // L
         5'd19: s = 7'h15;   // n
         5'd20: s = 7'h1D;   // o
         5'd21: s = 7'h67;   // P
         5'd22: s = 7'h05;   // r
         5'd23: s = 7'h0F;   // t
         5'd24: s = 7'h3E;   // U
         5'd25: s = 7'h3B;   // y
         5'd26: s = 7'h0D;   // c
         5'd27: s = 7'h17;   // h
         5'd28: s = 7'h1C;   // u
         5'd29: s = 7'h73;   // q
         5'd30: s = 7'h08;   // underscore
         default: s = 7'h40; // overline
      endcase
      return s;
   endfunction

   assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign in_ready = ~rst & ~w_full;
   assign w_ok     = ((^{E, P}) == PAR_TARGET);
   assign w_accept = in_valid & in_ready;
`ifdef DISPLAY_SCROLL_ERR_DROP_EN
   assign w_wr_en  = w_accept & w_ok;
`else
   assign w_wr_en  = w_accept;
`endif
   assign w_tick   = (r_scnt == SCROLL_MAX);
   // Pop only uses an entry that was already present before this edge
   assign w_pop    = w_tick & ~w_empty;
   assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
   assign level    = r_wr_ptr - r_rd_ptr;

   // FIFO data write (pointers alone define validity, so no reset needed)
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_ok, E};
      end
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Parity result of the last accepted character and saturating error count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b1;
         r_err   <= 8'd0;
      end else if (w_accept) begin
         r_valid <= w_ok;
         if (!w_ok && r_err != 8'hFF) r_err <= r_err + 8'd1;
      end
   end

   // Scroll timer
   always_ff @(posedge clk) begin
      if (rst)         r_scnt <= '0;
      else if (w_tick) r_scnt <= '0;
      else             r_scnt <= r_scnt + 1'b1;
   end

   // Shift the window one place on each tick that has a character to show
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dig_occ <= '0;
         r_dig_ok  <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) r_dig_code[i] <= 5'd0;
      end else if (w_pop) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--) r_dig_code[i] <= r_dig_code[i-1];
         r_dig_code[0] <= w_head[4:0];
         r_dig_ok      <= {r_dig_ok[NUM_DIGITS-2:0], w_head[5]};
         r_dig_occ     <= {r_dig_occ[NUM_DIGITS-2:0], 1'b1};
      end
   end

   // Refresh divider and digit select
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rcnt <= '0;
         r_sel  <= '0;
      end else if (r_rcnt == REFRESH_MAX) begin
         r_rcnt <= '0;
         r_sel  <= (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
      end else begin
         r_rcnt <= r_rcnt + 1'b1;
      end
   end

   // Decode the selected digit: blank, mapped glyph, or dash for a parity error
   always_comb begin
      w_seg = 7'b0000000;
      if (r_dig_occ[r_sel]) begin
         w_seg = r_dig_ok[r_sel] ? char_map(r_dig_code[r_sel]) : 7'b0000001;
      end
   end

   assign seg       = w_seg;
   assign an        = AN_ONE << r_sel;
   assign valid     = r_valid;
   assign err_count = r_err;

endmodule

// File: tb/tb_display_scroll_mux.sv
// Bench for display_scroll_mux. u_dut scrolls fast for the order, display and
// parity checks. u_full scrolls slowly for the full-FIFO and mid-operation
// reset checks.
module tb_display_scroll_mux;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst_f;
   logic rst_full;
   assign rst_full = rst | rst_f;

   // u_dut signals
   logic [4:0] e_a;
   logic       p_a;
   logic       in_valid_a;
   logic       in_ready_a;
   logic [6:0] seg_a;
   logic [3:0] an_a;
   logic       valid_a;
   logic [7:0] err_a;
   logic [3:0] level_a;

   // u_full signals
   logic [4:0] e_f;
   logic       p_f;
   logic       in_valid_f;
   logic       in_ready_f;
   logic [6:0] seg_f;
   logic [3:0] an_f;
   logic       valid_f;
   logic [7:0] err_f;
   logic [3:0] level_f;

   display_scroll_mux #(.NUM_DIGITS(4), .DEPTH(8), .REFRESH_DIV(2),
                        .SCROLL_DIV(4), .ODD_PARITY(0)) u_dut (
      .clk(clk), .rst(rst), .E(e_a), .P(p_a), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .seg(seg_a), .an(an_a), .valid(valid_a),
      .err_count(err_a), .level(level_a));

   display_scroll_mux #(.NUM_DIGITS(4), .DEPTH(8), .REFRESH_DIV(2),
                        .SCROLL_DIV(200), .ODD_PARITY(0)) u_full (
      .clk(clk), .rst(rst_full), .E(e_f), .P(p_f), .in_valid(in_valid_f),
      .in_ready(in_ready_f), .seg(seg_f), .an(an_f), .valid(valid_f),
      .err_count(err_f), .level(level_f));

   // Edges since u_full last saw reset; its scroll tick lands on multiples of 200
   int cyc_f = 0;
   always @(posedge clk) begin
      if (rst_full) cyc_f <= 0;
      else          cyc_f <= cyc_f + 1;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   logic [8:0]  exp_q[$];   // {valid, err_count} per accepted character
   logic [10:0] disp_q[$];  // {an, seg} per digit slot
   int m_err = 0;

   // Accept monitor: on each handshake, compare valid/err_count after the edge
   always begin
      logic [8:0] ex;
      @(posedge clk);
      if (in_valid_a && in_ready_a) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            fail_now("acc_unexpected");
         end else begin
            ex = exp_q.pop_front();
            check("acc_valid", {31'd0, valid_a}, {31'd0, ex[8]});
            check("acc_err", {24'd0, err_a}, {24'd0, ex[7:0]});
         end
      end
   end

   // Display monitor: syncs on entry into digit 0, then checks each slot
   logic       disp_en = 1'b0;
   logic       synced  = 1'b0;
   logic [3:0] prev_an = 4'd0;
   int         gap     = 0;

   task automatic disp_pop();
      logic [10:0] ex;
      ex = disp_q.pop_front();
      check("disp_an", {28'd0, an_a}, {28'd0, ex[10:7]});
      check("disp_seg", {25'd0, seg_a}, {25'd0, ex[6:0]});
      if (disp_q.size() == 0) synced = 1'b0;
   endtask

   always @(negedge clk) begin
      if (disp_en && disp_q.size() > 0) begin
         if (!synced) begin
            if (an_a == 4'b0001 && prev_an != 4'b0001) begin
               synced = 1'b1;
               gap = 1;
               disp_pop();
            end
         end else if (an_a != prev_an) begin
            check("slot_len", gap, 2);
            gap = 1;
            disp_pop();
         end else begin
            gap++;
         end
      end
      prev_an = an_a;
   end

   // ---------------- driver tasks ----------------
   task automatic send_a(input logic [4:0] e, input logic p);
      logic ok;
      int n;
      ok = ((^{e, p}) == 1'b0);
      if (!ok && m_err < 255) m_err++;
      exp_q.push_back({ok, 8'(m_err)});
      e_a = e;
      p_a = p;
      in_valid_a = 1'b1;
      n = 0;
      forever begin
         @(posedge clk);
         if (in_ready_a) break;
         n++;
         if (n > 100) begin
            fail_now("send_timeout");
            break;
         end
      end
      @(negedge clk);
      in_valid_a = 1'b0;
   endtask

   task automatic wait_empty_a();
      int g;
      g = 0;
      while (level_a != 4'd0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (level_a != 4'd0) fail_now("drain_timeout");
      repeat (4) @(negedge clk);
   endtask

   task automatic run_disp();
      int g;
      g = 0;
      disp_en = 1'b1;
      while (disp_q.size() > 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (disp_q.size() > 0) begin
         fail_now("disp_timeout");
         disp_q.delete();
      end
      disp_en = 1'b0;
      synced = 1'b0;
   endtask

   task automatic wait_cyc_f(input int n);
      int g;
      g = 0;
      while (cyc_f != n && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (cyc_f != n) fail_now("cyc_timeout");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [4:0] c;
      rst = 1'b1;
      rst_f = 1'b0;
      e_a = 5'd0; p_a = 1'b0; in_valid_a = 1'b0;
      e_f = 5'd0; p_f = 1'b0; in_valid_f = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", {31'd0, in_ready_a}, 32'd0);
      end
      check("rst_an", {28'd0, an_a}, 32'h1);
      check("rst_seg", {25'd0, seg_a}, 32'h0);
      check("rst_valid", {31'd0, valid_a}, 32'd1);
      check("rst_err", {24'd0, err_a}, 32'd0);
      check("rst_level", {28'd0, level_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", {31'd0, in_ready_a}, 32'd1);

      // Scroll order: 1, 2, 3 with even parity
      send_a(5'd1, 1'b1);
      send_a(5'd2, 1'b1);
      send_a(5'd3, 1'b0);
      wait_empty_a();
      for (int r = 0; r < 2; r++) begin
         disp_q.push_back({4'b0001, 7'h79});
         disp_q.push_back({4'b0010, 7'h6D});
         disp_q.push_back({4'b0100, 7'h30});
         disp_q.push_back({4'b1000, 7'h00});
      end
      run_disp();

      // Parity error: E=00011, P=1
      send_a(5'b00011, 1'b1);
      wait_empty_a();
`ifdef DISPLAY_SCROLL_ERR_DROP_EN
      send_a(5'd4, 1'b1);
      wait_empty_a();
      disp_q.push_back({4'b0001, 7'h33});
`else
      disp_q.push_back({4'b0001, 7'h01});
`endif
      disp_q.push_back({4'b0010, 7'h79});
      disp_q.push_back({4'b0100, 7'h6D});
      disp_q.push_back({4'b1000, 7'h30});
      run_disp();

      // Saturation: 299 more bad characters, then one good one
      for (int i = 0; i < 299; i++) send_a(5'b00011, 1'b1);
      send_a(5'd5, 1'b0);
      wait_empty_a();
      check("err_sat", {24'd0, err_a}, 32'd255);
      check("acc_left", exp_q.size(), 0);

      // Full FIFO on the slow-scroll instance
      rst_f = 1'b1;
      @(negedge clk);
      rst_f = 1'b0;
      in_valid_f = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         c = 5'(k);
         e_f = c;
         p_f = ^c;
         if (k < 9) @(negedge clk);
      end
      check("full_level", {28'd0, level_f}, 32'd8);
      check("full_ready", {31'd0, in_ready_f}, 32'd0);
      wait_cyc_f(199);
      check("full_hold", {28'd0, level_f}, 32'd8);
      @(negedge clk);
      check("pop_level", {28'd0, level_f}, 32'd7);
      check("pop_ready", {31'd0, in_ready_f}, 32'd1);
      @(negedge clk);
      check("ninth_level", {28'd0, level_f}, 32'd8);
      in_valid_f = 1'b0;

      // Mid-operation reset landing on a tick with five entries buffered
      rst_f = 1'b1;
      @(negedge clk);
      rst_f = 1'b0;
      in_valid_f = 1'b1;
      for (int k = 0; k < 5; k++) begin
         c = 5'(11 + k);
         e_f = c;
         p_f = ^c;
         @(negedge clk);
      end
      in_valid_f = 1'b0;
      check("fill5_level", {28'd0, level_f}, 32'd5);
      wait_cyc_f(200);
      check("tick_level", {28'd0, level_f}, 32'd4);
      c = 5'd16;
      e_f = c;
      p_f = ^c;
      in_valid_f = 1'b1;
      @(negedge clk);
      in_valid_f = 1'b0;
      check("refill_level", {28'd0, level_f}, 32'd5);
      wait_cyc_f(399);
      rst_f = 1'b1;
      @(negedge clk);
      check("mid_level", {28'd0, level_f}, 32'd0);
      check("mid_an", {28'd0, an_f}, 32'h1);
      check("mid_seg", {25'd0, seg_f}, 32'h0);
      check("mid_valid", {31'd0, valid_f}, 32'd1);
      check("mid_ready", {31'd0, in_ready_f}, 32'd0);
      rst_f = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mid_blank", {25'd0, seg_f}, 32'h0);
      end
      check("mid_ready_after", {31'd0, in_ready_f}, 32'd1);

      // Bad character then good one on the slow instance
      e_f = 5'b00011; p_f = 1'b1; in_valid_f = 1'b1;
      @(negedge clk);
      e_f = 5'd4; p_f = 1'b1;
      @(negedge clk);
      in_valid_f = 1'b0;
      check("mix_err", {24'd0, err_f}, 32'd1);
      check("mix_valid", {31'd0, valid_f}, 32'd1);
`ifdef DISPLAY_SCROLL_ERR_DROP_EN
      check("mix_level", {28'd0, level_f}, 32'd1);
`else
      check("mix_level", {28'd0, level_f}, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_scroll_mux.md
Name: display_scroll_mux

Overview:
- Parametrised successor to the single-digit parity-checked display.
- Accepts a stream of 5-bit characters, each with a parity bit, over a valid/ready handshake, and buffers them in a FIFO.
- Scrolls characters into an N-digit window and time-multiplexes the digits onto one shared 7-segment bus with a one-hot digit enable.
- Counts parity errors; sits between the character source and the board's multi-digit display.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8)
- DEPTH, 8, FIFO entries, power of two (2..16)
- REFRESH_DIV, 1000, clock cycles per multiplexed digit slot (>=2)
- SCROLL_DIV, 50000000, clock cycles between scroll ticks (>=2)
- ODD_PARITY, 0, 0: a character is valid when XOR of {E,P} is 0; 1: valid when that XOR is 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- E  in  5  character code
- P  in  1  parity bit for E
- in_valid  in  1  E/P present
- in_ready  out  1  FIFO can accept
- seg  out  7  segments, active-high; bit6=A … bit0=G
- an  out  NUM_DIGITS  one-hot digit enable, active-high
- valid  out  1  parity result of the most recently accepted character
- err_count  out  8  saturating count of parity-invalid accepted characters
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - FIFO empty, level=0, all digits unoccupied, all counters 0, sel=0.
  - an = 1 (digit 0 enabled), seg = 0, valid = 1, err_count = 0.
  - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after rst is released.
- Reset mid-operation: discards FIFO and digit contents immediately and returns every output to its reset value.
- Handshake:
  - A character is accepted when in_valid & in_ready at a clk edge.
  - in_ready = !full, registered-state based.
  - No push occurs while full, even if a pop happens the same cycle.
  - E and P must be held until accepted.
- Parity check on accept:
  - ok = (^{E,P}) == ODD_PARITY.
  - valid <= ok.
  - If !ok, err_count increments and saturates at 255.
  - The FIFO entry stores {ok, E}.
- Scroll timer:
  - scnt counts 0..SCROLL_DIV-1 and wraps; tick = (scnt == SCROLL_DIV-1).
  - On tick with FIFO non-empty: digit[i] <= digit[i-1] for i = NUM_DIGITS-1..1, digit[0] <= FIFO head (marked occupied), FIFO pops.
  - The oldest character falls off digit NUM_DIGITS-1.
  - On tick with FIFO empty: nothing changes.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - With the FIFO empty, a push on a tick cycle is not popped on that tick; the pop needs an entry present at the edge.
- Multiplexing:
  - rcnt counts 0..REFRESH_DIV-1.
  - On wrap, sel increments; sel wraps from NUM_DIGITS-1 to 0.
  - an = one-hot(sel).
  - seg is decoded combinationally from digit[sel], so seg and an change on the same edge.
- Segment decode per digit:
  - Unoccupied digit: 7'b0000000.
  - Occupied with ok=1: the team's standard 5-bit character map, identical to the single-digit display.
  - Occupied with ok=0: dash, 7'b0000001 (G only).
- FIFO: circular buffer with wrap-around read/write pointers plus one extra bit for full/empty; level = wr - rd.

Optional Feature:
- Macro DISPLAY_SCROLL_ERR_DROP_EN.
- Defined: parity-invalid characters are still handshaken (in_ready unchanged), still update valid and err_count, but are not written to the FIFO, so level is unchanged.
- Undefined: invalid characters are buffered and displayed as a dash.

Test Plan:
- Reset:
  - Stimulus: hold rst 3 cycles, then release.
  - Required: an=0001, seg=0, valid=1, err_count=0, level=0; in_ready=0 during reset, 1 on the first cycle after release.
- Scroll order (SCROLL_DIV=4, REFRESH_DIV=2):
  - Stimulus: push E=1,2,3 with even-correct P.
  - Required: after 3 ticks digit0=3, digit1=2, digit2=1, digit3 blank; an cycles 0001→0010→0100→1000→0001 every 2 cycles; seg matches each digit's map.
- Full FIFO (DEPTH=8, scroll held by large SCROLL_DIV):
  - Stimulus: push 9 characters with in_valid held.
  - Required: level=8 and in_ready=0 after the 8th; the 9th is accepted only on the cycle after the first pop.
- Parity error:
  - Stimulus: push E=5'b00011 with P=1.
  - Required: valid=0, err_count=1; once scrolled in, that digit shows seg=7'b0000001.
  - Repeat: 300 such pushes leave err_count=255.
- Mid-operation reset:
  - Stimulus: fill 5 entries, assert rst for 1 cycle during a tick.
  - Required: level=0, all digits blank, an=0001.
- With DISPLAY_SCROLL_ERR_DROP_EN defined:
  - Stimulus: push a bad character then a good one.
  - Required: level=1, err_count=1, only the good character is displayed.
